// File: rtl/lfsr_checker_if.sv
// Sample stream and status bundle between the 4-bit LFSR stage and its checker.
// The producer side drives samples and clear; the checker reports lock, errors and period.
interface lfsr_checker_if #(
    parameter int CNT_W = 16
);
    logic             vld_i;
    logic [3:0]       lfsr_i;
    logic             clr_i;
    logic             locked_o;
    logic             err_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic [7:0]       period_o;
    logic             zero_o;

    modport master (
        output vld_i, lfsr_i, clr_i,
        input  locked_o, err_o, err_cnt_o, period_o, zero_o
    );

    modport slave (
        input  vld_i, lfsr_i, clr_i,
        output locked_o, err_o, err_cnt_o, period_o, zero_o
    );
endinterface

// File: rtl/lfsr_checker.sv
// Self-check stage for the 4-bit LFSR (feedback q[3]^q[1], shift left): locks onto
// the sample stream, flags and counts mispredictions, spots the stuck-zero state and
// measures the seed-to-seed period.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no reference yet; first non-zero sample seeds the predictor
// ST_SYNC | re-seeding from every sample, counting consecutive matches
// ST_LOCK | free-running predictor, errors counted, period measured
module lfsr_checker #(
    parameter logic [3:0] SEED     = 4'hE,
    parameter int         LOCK_CNT = 4,
    parameter int         LOSS_CNT = 3,
    parameter int         CNT_W    = 16
) (
    input logic           clk,
    input logic           reset,
    lfsr_checker_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LOCK
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       pred_q, pred_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic [7:0]       per_cnt_q, per_cnt_d;
    logic             seed_seen_q, seed_seen_d;
    logic             err_q, err_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       period_q, period_d;
    logic [3:0]       s;

    function automatic logic [3:0] lfsr_next(input logic [3:0] x);
        return {x[2:0], x[3] ^ x[1]};
    endfunction

    assign s = bus.lfsr_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_q      <= 4'h0;
            match_cnt_q <= 4'h0;
            miss_cnt_q  <= 4'h0;
            per_cnt_q   <= 8'h00;
            seed_seen_q <= 1'b0;
            err_q       <= 1'b0;
            zero_q      <= 1'b0;
            err_cnt_q   <= '0;
            period_q    <= 8'h00;
        end else begin
            pred_q      <= pred_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            per_cnt_q   <= per_cnt_d;
            seed_seen_q <= seed_seen_d;
            err_q       <= err_d;
            zero_q      <= zero_d;
            err_cnt_q   <= err_cnt_d;
            period_q    <= period_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        per_cnt_d   = per_cnt_q;
        seed_seen_d = seed_seen_q;
        err_d       = 1'b0;
        zero_d      = 1'b0;
        err_cnt_d   = err_cnt_q;
        period_d    = period_q;

        if (bus.vld_i) begin
            zero_d = (s == 4'h0);
            case (state_q)
                ST_IDLE: begin
                    if (s != 4'h0) begin
                        pred_d      = lfsr_next(s);
                        match_cnt_d = 4'h0;
                        state_d     = ST_SYNC;
                    end
                end

                ST_SYNC: begin
                    if (s == 4'h0) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (s == pred_q) begin
                            match_cnt_d = match_cnt_q + 4'd1;
                            if (match_cnt_d == 4'(LOCK_CNT)) begin
                                state_d     = ST_LOCK;
                                miss_cnt_d  = 4'h0;
                                seed_seen_d = 1'b0;
                            end
                        end else begin
                            match_cnt_d = 4'h0;
                        end
                        pred_d = lfsr_next(s);
                    end
                end

                ST_LOCK: begin
                    // Predictor runs on its own state so a single bad sample costs one error.
                    pred_d = lfsr_next(pred_q);

                    if (s == SEED) begin
                        if (seed_seen_q) begin
                            period_d = per_cnt_q;
                        end
                        per_cnt_d   = 8'd1;
                        seed_seen_d = 1'b1;
                    end else if (per_cnt_q != 8'hFF) begin
                        per_cnt_d = per_cnt_q + 8'd1;
                    end

                    if (s != pred_q) begin
                        err_d      = 1'b1;
                        miss_cnt_d = miss_cnt_q + 4'd1;
                        if (err_cnt_q != {CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                        if (miss_cnt_d == 4'(LOSS_CNT)) begin
                            state_d     = ST_SYNC;
                            match_cnt_d = 4'h0;
                            pred_d      = lfsr_next(s);
                            seed_seen_d = 1'b0;
                        end
                    end else begin
                        miss_cnt_d = 4'h0;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end

        // Clear beats a coincident increment; the err_o pulse itself is unaffected.
        if (bus.clr_i) begin
            err_cnt_d = '0;
            period_d  = 8'h00;
        end
    end

    assign bus.locked_o  = (state_q == ST_LOCK);
    assign bus.err_o     = err_q;
    assign bus.zero_o    = zero_q;
    assign bus.err_cnt_o = err_cnt_q;
    assign bus.period_o  = period_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: directed sample stream with hand-derived
// expected outputs, queued at issue and compared by an independent monitor.
module tb_lfsr_checker;

    logic clk;
    logic reset;

    lfsr_checker_if #(.CNT_W(16)) bus ();

    lfsr_checker #(
        .SEED     (4'hE),
        .LOCK_CNT (4),
        .LOSS_CNT (3),
        .CNT_W    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        lk;
        logic        er;
        logic [15:0] cnt;
        logic [7:0]  per;
        logic        z;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_idx = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input int idx, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("locked", e.idx, 16'(bus.locked_o), 16'(e.lk));
            cmp("err",    e.idx, 16'(bus.err_o),    16'(e.er));
            cmp("err_cnt", e.idx, bus.err_cnt_o,    e.cnt);
            cmp("period", e.idx, 16'(bus.period_o), 16'(e.per));
            cmp("zero",   e.idx, 16'(bus.zero_o),   16'(e.z));
        end
    end

    task automatic step(input logic v, input logic [3:0] s, input logic c,
                        input logic lk, input logic er, input logic [15:0] cnt,
                        input logic [7:0] per, input logic z);
        exp_t e;
        bus.vld_i  = v;
        bus.lfsr_i = s;
        bus.clr_i  = c;
        @(posedge clk);
        e.lk = lk; e.er = er; e.cnt = cnt; e.per = per; e.z = z; e.idx = step_idx;
        exp_q.push_back(e);
        step_idx++;
        #1;
    endtask

    task automatic gap(input logic lk, input logic [15:0] cnt, input logic [7:0] per);
        step(1'b0, 4'h0, 1'b0, lk, 1'b0, cnt, per, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        bus.vld_i  = 1'b0;
        bus.lfsr_i = 4'h0;
        bus.clr_i  = 1'b0;
        step(1'b0, 4'h0, 1'b0, 0, 0, 0, 0, 0);
        step(1'b1, 4'hE, 1'b0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // zero from IDLE: pulse, stay unlocked
        step(1, 4'h0, 0, 0, 0, 0, 0, 1);
        gap(0, 0, 0);

        // clean stream: lock on 5th sample, period 6 on second seed in LOCK
        step(1, 4'hE, 0, 0, 0, 0, 0, 0);
        step(1, 4'hC, 0, 0, 0, 0, 0, 0);
        step(1, 4'h9, 0, 0, 0, 0, 0, 0);
        step(1, 4'h3, 0, 0, 0, 0, 0, 0);
        step(1, 4'h7, 0, 1, 0, 0, 0, 0);
        step(1, 4'hF, 0, 1, 0, 0, 0, 0);
        step(1, 4'hE, 0, 1, 0, 0, 0, 0);
        step(1, 4'hC, 0, 1, 0, 0, 0, 0);
        step(1, 4'h9, 0, 1, 0, 0, 0, 0);
        step(1, 4'h3, 0, 1, 0, 0, 0, 0);
        step(1, 4'h7, 0, 1, 0, 0, 0, 0);
        step(1, 4'hF, 0, 1, 0, 0, 0, 0);
        step(1, 4'hE, 0, 1, 0, 0, 6, 0);
        step(1, 4'hC, 0, 1, 0, 0, 6, 0);
        step(1, 4'h9, 0, 1, 0, 0, 6, 0);

        // single corrupted sample: one error, lock held, no follow-on errors
        step(1, 4'h5, 0, 1, 1, 1, 6, 0);
        step(1, 4'h7, 0, 1, 0, 1, 6, 0);
        step(1, 4'hF, 0, 1, 0, 1, 6, 0);
        step(1, 4'hE, 0, 1, 0, 1, 6, 0);
        step(1, 4'hC, 0, 1, 0, 1, 6, 0);
        step(1, 4'h9, 1, 1, 0, 0, 0, 0);

        // three consecutive misses drop lock; relock after four matches
        step(1, 4'h5, 0, 1, 1, 1, 0, 0);
        step(1, 4'h5, 0, 1, 1, 2, 0, 0);
        step(1, 4'h5, 0, 0, 1, 3, 0, 0);
        step(1, 4'hE, 0, 0, 0, 3, 0, 0);
        step(1, 4'hC, 0, 0, 0, 3, 0, 0);
        step(1, 4'h9, 0, 0, 0, 3, 0, 0);
        step(1, 4'h3, 0, 0, 0, 3, 0, 0);
        step(1, 4'h7, 0, 1, 0, 3, 0, 0);
        step(1, 4'hF, 0, 1, 0, 3, 0, 0);
        step(1, 4'hE, 0, 1, 0, 3, 0, 0);

        // zero while locked: zero and err pulse, count +1
        step(1, 4'h0, 0, 1, 1, 4, 0, 1);
        step(1, 4'h9, 0, 1, 0, 4, 0, 0);

        // clear coincident with an error
        step(1, 4'h5, 1, 1, 1, 0, 0, 0);
        step(1, 4'h7, 0, 1, 0, 0, 0, 0);

        // reset mid-LOCK
        @(negedge clk);
        #1;
        reset = 1'b1;
        step(0, 4'h0, 0, 0, 0, 0, 0, 0);
        step(0, 4'h0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // gapped clean stream: same lock point in samples, period 6
        step(1, 4'hE, 0, 0, 0, 0, 0, 0); gap(0, 0, 0);
        step(1, 4'hC, 0, 0, 0, 0, 0, 0); gap(0, 0, 0);
        step(1, 4'h9, 0, 0, 0, 0, 0, 0); gap(0, 0, 0);
        step(1, 4'h3, 0, 0, 0, 0, 0, 0); gap(0, 0, 0);
        step(1, 4'h7, 0, 1, 0, 0, 0, 0); gap(1, 0, 0);
        step(1, 4'hF, 0, 1, 0, 0, 0, 0); gap(1, 0, 0);
        step(1, 4'hE, 0, 1, 0, 0, 0, 0); gap(1, 0, 0);
        step(1, 4'hC, 0, 1, 0, 0, 0, 0); gap(1, 0, 0);
        step(1, 4'h9, 0, 1, 0, 0, 0, 0); gap(1, 0, 0);
        step(1, 4'h3, 0, 1, 0, 0, 0, 0); gap(1, 0, 0);
        step(1, 4'h7, 0, 1, 0, 0, 0, 0); gap(1, 0, 0);
        step(1, 4'hF, 0, 1, 0, 0, 0, 0); gap(1, 0, 0);
        step(1, 4'hE, 0, 1, 0, 0, 6, 0); gap(1, 0, 6);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Sequence checker that sits directly downstream of the 4-bit LFSR stage (feedback bit = q[3] ^ q[1], shift left, seed 4'hE). It consumes the LFSR output sample stream and synchronizes to it. Once synchronized, it predicts every next value, flags and counts mismatches, detects the stuck all-zero state, and measures the sequence period between seed occurrences. It serves as the self-check and monitor stage for the LFSR.

## Interface
Parameters:
- SEED, 4'hE: value used to mark period boundaries.
- LOCK_CNT, 4: consecutive correct predictions in SYNC required to lock; 1..15.
- LOSS_CNT, 3: consecutive mispredictions in LOCK that drop lock; 1..15.
- CNT_W, 16: error counter width.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high.
- vld_i, in, 1: lfsr_i carries a sample this cycle.
- lfsr_i, in, 4: LFSR sample.
- clr_i, in, 1: synchronous clear of err_cnt_o and period_o.
- locked_o, out, 1: checker is in LOCK.
- err_o, out, 1: one-cycle pulse; the previous accepted sample mispredicted while in LOCK.
- err_cnt_o, out, CNT_W: saturating mismatch count.
- period_o, out, 8: last measured seed-to-seed period; 0 means not yet measured.
- zero_o, out, 1: one-cycle pulse; the previous accepted sample was 4'h0.

## Operation
- Define next(x) = {x[2:0], x[3]^x[1]}.
- Internal registers: pred (4b), match_cnt, miss_cnt (4b each), per_cnt (8b), seed_seen, and the state.
- Cycles with vld_i=0 change nothing except clr_i handling. Output pulses deassert.

FSM states (IDLE, SYNC, LOCK), evaluated on each accepted sample s:
- IDLE: if s==0, stay in IDLE. Otherwise pred<=next(s), match_cnt<=0, go to SYNC.
- SYNC:
  - If s==0: go to IDLE.
  - Else if s==pred: match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCK with miss_cnt<=0, seed_seen<=0.
  - Else: match_cnt<=0.
  - In every non-zero case, pred<=next(s). The checker re-seeds from the input.
- LOCK:
  - pred<=next(pred). The checker is free-running and does not re-seed, so one corrupted sample yields exactly one error.
  - If s!=pred: err_o pulse, err_cnt_o increments (saturating at all-ones), miss_cnt++.
  - If miss_cnt reaches LOSS_CNT: go to SYNC with match_cnt<=0, pred<=next(s), seed_seen<=0.
  - If s==pred: miss_cnt<=0.
  - s==0 is an ordinary mismatch, because pred is never 0.

Period measurement (LOCK only, using the received sample s):
- If s==SEED and seed_seen=1: period_o<=per_cnt, then per_cnt<=1.
- If s==SEED and seed_seen=0: per_cnt<=1, seed_seen<=1.
- Otherwise: per_cnt<=per_cnt+1, saturating at 255.

Other rules:
- zero_o pulses for any accepted s==0, in any state.
- clr_i zeroes err_cnt_o and period_o. If clr_i coincides with an error, clr_i wins: the count becomes 0, but err_o still pulses. clr_i does not affect the FSM, pred, or per_cnt.
- Reset values:
  - state IDLE, locked_o=0, err_o=0, zero_o=0.
  - err_cnt_o=0, period_o=0.
  - pred=0, match_cnt=0, miss_cnt=0, per_cnt=0, seed_seen=0.

## Timing
- All outputs are registered and update on the clk edge that accepts the sample. There is no combinational path from input to output.
- err_o and zero_o are high for exactly the one cycle after the offending accepted sample.
- Lock latency: with a clean stream, locked_o rises on the edge accepting sample number LOCK_CNT+1.
- Loss latency: locked_o falls on the edge accepting the LOSS_CNT-th consecutive bad sample.
- Reset asserted mid-operation immediately forces IDLE and all reset values. The first sample after release is treated as a fresh seed.
- Back-to-back vld_i is supported every cycle. Gaps in vld_i are transparent: the checker counts samples, not cycles.

## Test plan
1. Clean stream E,C,9,3,7,F,E,... with vld_i=1 continuously: locked_o rises after the 7 (5th sample), err_cnt_o stays 0, and period_o=6 after the second E seen in LOCK.
2. Locked, then inject 5 in place of an expected 3: single err_o pulse, err_cnt_o=1, locked_o stays 1, and the following samples produce no errors.
3. Locked, then 3 consecutive wrong samples (5,5,5): err_cnt_o=3 and locked_o falls after the third. Resuming the clean stream relocks after 4 more matches.
4. Send 0 from IDLE and then from LOCK: zero_o pulses each time. IDLE stays IDLE. In LOCK, err_cnt_o increments by 1.
5. Clean stream with vld_i toggling 1,0,1,0: same lock point in samples, and period_o=6.
6. clr_i pulsed in the same cycle an error is accepted: err_o=1, err_cnt_o=0. Reset mid-LOCK: all outputs return to 0 on the next cycle.
